// File: rtl/pipelined_adder_nbit.sv
// pipelined_adder_nbit: n-bit add/subtract built from STAGES registered carry-chain slices.
// Define ADDER_OVF_EN to add out_v, the registered signed-overflow flag aligned with out_s.

module pipelined_adder_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] s_o,
    output logic         c_o
);
    assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, c_i};
endmodule

module pipelined_adder_nbit #(
    parameter int n      = 32,
    parameter int STAGES = 4
) (
    input  logic         in_clk,
    input  logic         in_rst,
    input  logic         in_valid,
    output logic         out_ready,
    input  logic [n-1:0] in_x,
    input  logic [n-1:0] in_y,
    input  logic         in_c,
    input  logic         in_sub,
    output logic         out_valid,
    input  logic         in_ready,
    output logic [n-1:0] out_s,
    output logic         out_c
`ifdef ADDER_OVF_EN
   ,output logic         out_v
`endif
);
    localparam int W = n / STAGES;

    logic              adv;
    logic [STAGES:0]   vld_pipe;
    logic [STAGES-1:0] vld_q;
    logic [n-1:0]      y_cap;
    logic              c_cap;

    // Stalls are global: every stage moves together or not at all.
    assign adv       = !out_valid || in_ready;
    assign out_ready = adv;

    assign vld_pipe[0]        = in_valid;
    assign vld_pipe[STAGES:1] = vld_q;
    assign out_valid          = vld_pipe[STAGES];

    // Subtract folds into the same adder as x + ~y + !borrow_in.
    assign y_cap = in_sub ? ~in_y : in_y;
    assign c_cap = in_sub ? ~in_c : in_c;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            vld_q <= '0;
        end else if (adv) begin
            vld_q <= vld_pipe[STAGES-1:0];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int SW = (k + 1) * W;

        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [W-1:0]  s;
        logic          ci;
        logic          co;
        logic [SW-1:0] s_d;
        logic [SW-1:0] s_q;
        logic          c_q;

        if (k == 0) begin : g_src
            assign a   = in_x[W-1:0];
            assign b   = y_cap[W-1:0];
            assign ci  = c_cap;
            assign s_d = s;
        end else begin : g_src
            assign a   = g_stg[k-1].g_op.x_q[W-1:0];
            assign b   = g_stg[k-1].g_op.y_q[W-1:0];
            assign ci  = g_stg[k-1].c_q;
            assign s_d = {s, g_stg[k-1].s_q};
        end

        pipelined_adder_slice #(.W(W)) u_slice (
            .a_i (a),
            .b_i (b),
            .c_i (ci),
            .s_o (s),
            .c_o (co)
        );

        always_ff @(posedge in_clk) begin
            if (in_rst) begin
                s_q <= '0;
                c_q <= 1'b0;
            end else if (adv) begin
                s_q <= s_d;
                c_q <= co;
            end
        end

        // Upper operand slices still waiting for their carry; the last stage has none left.
        if (k < STAGES - 1) begin : g_op
            localparam int OW = n - SW;

            logic [OW-1:0] x_d;
            logic [OW-1:0] y_d;
            logic [OW-1:0] x_q;
            logic [OW-1:0] y_q;

            if (k == 0) begin : g_fwd
                assign x_d = in_x[n-1:W];
                assign y_d = y_cap[n-1:W];
            end else begin : g_fwd
                assign x_d = g_stg[k-1].g_op.x_q[OW+W-1:W];
                assign y_d = g_stg[k-1].g_op.y_q[OW+W-1:W];
            end

            always_ff @(posedge in_clk) begin
                if (in_rst) begin
                    x_q <= '0;
                    y_q <= '0;
                end else if (adv) begin
                    x_q <= x_d;
                    y_q <= y_d;
                end
            end
        end
    end

    assign out_s = g_stg[STAGES-1].s_q;
    assign out_c = g_stg[STAGES-1].c_q;

`ifdef ADDER_OVF_EN
    logic v_d;
    logic v_q;

    // Carry into the MSB is recovered from its sum bit, since s = a ^ b ^ cin.
    assign v_d = g_stg[STAGES-1].co ^
                 (g_stg[STAGES-1].s[W-1] ^ g_stg[STAGES-1].a[W-1] ^ g_stg[STAGES-1].b[W-1]);

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            v_q <= 1'b0;
        end else if (adv) begin
            v_q <= v_d;
        end
    end

    assign out_v = v_q;
`endif
endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// Bench for pipelined_adder_nbit: three instances (STAGES 4, 1, 32) share stimulus and are
// checked against an arithmetic scoreboard plus directed literal expectations.
`timescale 1ns/1ps
module tb_pipelined_adder_nbit;
    localparam int ND = 3;
`ifdef ADDER_OVF_EN
    localparam logic [33:0] M = {34{1'b1}};
`else
    localparam logic [33:0] M = {1'b0, {33{1'b1}}};
`endif

    logic          clk = 1'b0;
    logic          rst, vin, cin, sub;
    logic [31:0]   x, y;
    logic [ND-1:0] i_rdy, o_rdy, o_vld, o_c, o_v;
    logic [31:0]   o_s [ND];
    int            n_chk = 0;
    int            n_pass = 0;
    logic [31:0]   sx [8];
    logic [31:0]   sy [8];
    logic          sc [8];
    logic          ss [8];

    always #5 clk = ~clk;

    pipelined_adder_nbit #(.n(32), .STAGES(4)) u_dut4 (
        .in_clk(clk), .in_rst(rst), .in_valid(vin), .out_ready(o_rdy[0]),
        .in_x(x), .in_y(y), .in_c(cin), .in_sub(sub),
        .out_valid(o_vld[0]), .in_ready(i_rdy[0]), .out_s(o_s[0]), .out_c(o_c[0])
`ifdef ADDER_OVF_EN
       ,.out_v(o_v[0])
`endif
    );
    pipelined_adder_nbit #(.n(32), .STAGES(1)) u_dut1 (
        .in_clk(clk), .in_rst(rst), .in_valid(vin), .out_ready(o_rdy[1]),
        .in_x(x), .in_y(y), .in_c(cin), .in_sub(sub),
        .out_valid(o_vld[1]), .in_ready(i_rdy[1]), .out_s(o_s[1]), .out_c(o_c[1])
`ifdef ADDER_OVF_EN
       ,.out_v(o_v[1])
`endif
    );
    pipelined_adder_nbit #(.n(32), .STAGES(32)) u_dut32 (
        .in_clk(clk), .in_rst(rst), .in_valid(vin), .out_ready(o_rdy[2]),
        .in_x(x), .in_y(y), .in_c(cin), .in_sub(sub),
        .out_valid(o_vld[2]), .in_ready(i_rdy[2]), .out_s(o_s[2]), .out_c(o_c[2])
`ifdef ADDER_OVF_EN
       ,.out_v(o_v[2])
`endif
    );
`ifndef ADDER_OVF_EN
    assign o_v = '0;
`endif

    function automatic int lat(input int d);
        return (d == 0) ? 4 : (d == 1) ? 1 : 32;
    endfunction

    // Reference result {v, c, s} from plain integer arithmetic.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic c, input logic s);
        longint ua, ub, sa, sbv, r, sr;
        logic   co, v;
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        if (!s) begin
            r  = ua + ub + longint'(c);
            co = (r > 64'sd4294967295);
            sr = sa + sbv + longint'(c);
        end else begin
            r  = ua - ub - longint'(c);
            co = (r >= 64'sd0);
            sr = sa - sbv - longint'(c);
        end
        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return {v, co, r[31:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    for (genvar d = 0; d < ND; d++) begin : g_mon
        logic [33:0] sb [$];
        logic [33:0] e;
        always @(negedge clk) begin
            if (rst) begin
                sb.delete();
            end else begin
                if (o_vld[d] && i_rdy[d]) begin
                    if (sb.size() == 0) begin
                        chk($sformatf("spurious_out_dut%0d", d), 64'(o_vld[d]), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("sb_result_dut%0d", d),
                            64'({o_v[d], o_c[d], o_s[d]} & M), 64'(e & M));
                    end
                end
                if (vin && o_rdy[d]) sb.push_back(model(x, y, cin, sub));
            end
        end
    end

    task automatic beat(input string nm, input logic [31:0] bx, input logic [31:0] by,
                        input logic bc, input logic bs, input logic [33:0] exp);
        @(posedge clk); #1;
        x = bx; y = by; cin = bc; sub = bs; vin = 1'b1; i_rdy = '1;
        @(negedge clk);
        for (int d = 0; d < ND; d++) chk($sformatf("%s_rdy_dut%0d", nm, d), 64'(o_rdy[d]), 64'd1);
        @(posedge clk); #1;
        vin = 1'b0;
        for (int t = 1; t <= 33; t++) begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                if (t == lat(d)) begin
                    chk($sformatf("%s_vld_dut%0d", nm, d), 64'(o_vld[d]), 64'd1);
                    chk($sformatf("%s_val_dut%0d", nm, d),
                        64'({o_v[d], o_c[d], o_s[d]} & M), 64'(exp & M));
                end else if (t == lat(d) - 1 || t == lat(d) + 1) begin
                    chk($sformatf("%s_novld_t%0d_dut%0d", nm, t, d), 64'(o_vld[d]), 64'd0);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  i, cyc, pend;
        logic stall, acc;
        rst = 1'b1; vin = 1'b0; x = '0; y = '0; cin = 1'b0; sub = 1'b0; i_rdy = '1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("rst_vld_dut%0d", d), 64'(o_vld[d]), 64'd0);
            chk($sformatf("rst_s_dut%0d", d),   64'(o_s[d]),   64'd0);
            chk($sformatf("rst_c_dut%0d", d),   64'(o_c[d]),   64'd0);
            chk($sformatf("rst_v_dut%0d", d),   64'(o_v[d] & M[33]), 64'd0);
            chk($sformatf("rst_rdy_dut%0d", d), 64'(o_rdy[d]), 64'd1);
        end

        beat("add_chain",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h0000_0000});
        beat("sub_borrow", 32'd5, 32'd7, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE});
        beat("sub_bin",    32'd7, 32'd5, 1'b1, 1'b1, {1'b0, 1'b1, 32'h0000_0001});
        beat("add_cin",    32'h0000_FFFF, 32'h0, 1'b1, 1'b0, {1'b0, 1'b0, 32'h0001_0000});
`ifdef ADDER_OVF_EN
        beat("ovf_add",    32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, {1'b1, 1'b0, 32'h8000_0000});
        beat("ovf_sub",    32'h8000_0000, 32'd1, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFF_FFFF});
        beat("no_ovf",     32'd1, 32'd1, 1'b0, 1'b0, {1'b0, 1'b0, 32'h0000_0002});
`endif

        // Streaming with a three-cycle downstream stall on the STAGES=4 instance.
        for (int k = 0; k < 8; k++) begin
            sx[k] = $urandom; sy[k] = $urandom; sc[k] = 1'($urandom); ss[k] = 1'($urandom);
        end
        i = 0; cyc = 0;
        @(posedge clk); #1;
        while (i < 8 && cyc < 40) begin
            stall    = (cyc >= 5 && cyc < 8);
            i_rdy[0] = !stall;
            vin = 1'b1; x = sx[i]; y = sy[i]; cin = sc[i]; sub = ss[i];
            @(negedge clk);
            if (stall) begin
                chk($sformatf("stall_vld_c%0d", cyc), 64'(o_vld[0]), 64'd1);
                chk($sformatf("stall_rdy_c%0d", cyc), 64'(o_rdy[0]), 64'd0);
                chk($sformatf("stall_hold_c%0d", cyc),
                    64'({o_v[0], o_c[0], o_s[0]} & M), 64'(g_mon[0].sb[0] & M));
            end else begin
                chk($sformatf("stream_rdy_c%0d", cyc), 64'(o_rdy[0]), 64'd1);
            end
            acc = o_rdy[0];
            @(posedge clk); #1;
            if (acc) i++;
            cyc++;
        end
        vin = 1'b0; i_rdy = '1;
        chk("stream_beats", 64'(i), 64'd8);
        chk("stream_cycles", 64'(cyc), 64'd11);
        pend = 1;
        for (int t = 0; t < 60 && pend != 0; t++) begin
            @(negedge clk);
            pend = g_mon[0].sb.size() + g_mon[1].sb.size() + g_mon[2].sb.size();
        end
        chk("drain_empty", 64'(pend), 64'd0);

        // Reset with beats in flight: none of them may ever emerge.
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            vin = 1'b1; x = $urandom; y = $urandom; cin = 1'b0; sub = 1'b0;
            @(posedge clk); #1;
        end
        vin = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < ND; d++) chk($sformatf("post_rst_rdy_dut%0d", d), 64'(o_rdy[d]), 64'd1);
        for (int t = 0; t < 6; t++) begin
            if (t > 0) @(negedge clk);
            for (int d = 0; d < ND; d++)
                chk($sformatf("post_rst_vld_t%0d_dut%0d", t, d), 64'(o_vld[d]), 64'd0);
        end
        repeat (36) @(negedge clk);
        chk("post_rst_quiet", 64'(o_vld), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
